// File: rtl/fib_random_decoder_pkg.sv
// Shared constants for the Fibonacci encoder/decoder pair: widths, FSM encodings, weight helper.
package fib_random_decoder_pkg;

    localparam int unsigned FIB_W     = 64;
    localparam int unsigned BIN_W     = 16;
    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned ACC_W     = 24;
    localparam int unsigned ROM_DEPTH = 1 << ADDR_W;

    // Decoder FSM encodings
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StScan = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StAcc  = 2'd3;

    // Weight of bit i is F(i+2) (1, 2, 3, 5, 8, ...), saturated to BIN_W bits as stored in the ROM.
    function automatic logic [BIN_W-1:0] fib_weight(input int unsigned idx);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] t;
        a = 32'd1;
        b = 32'd2;
        for (int unsigned k = 0; k < FIB_W; k++) begin
            if (k < idx) begin
                t = a + b;
                a = b;
                b = (t > 32'h0000_FFFF) ? 32'h0001_0000 : t;
            end
        end
        fib_weight = (a > 32'h0000_FFFF) ? 16'hFFFF : a[BIN_W-1:0];
    endfunction

endpackage

// File: rtl/fib_random_decoder.sv
// Fibonacci-system (possibly non-canonical) 64-bit word to 16-bit binary decoder.
// Scans the word LSB-first; each set bit triggers one external ROM read whose weight is accumulated.
module fib_random_decoder
    import fib_random_decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              en_decode,
    input  logic [FIB_W-1:0]  fibonacci_in,
    input  logic [BIN_W-1:0]  memb,
    output logic [ADDR_W-1:0] cnt_b,
    output logic [BIN_W-1:0]  binary_out,
    output logic              decode_done,
    output logic              busy,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FIB_W - 1);

    logic [1:0]        state_q, state_d;
    logic [FIB_W-1:0]  shift_q, shift_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [BIN_W-1:0]  hold_q, hold_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    // Next-state and datapath updates for the scan/fetch/accumulate loop
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        hold_d  = hold_q;
        bin_d   = bin_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            StIdle: begin
                if (en_decode) begin
                    shift_d = fibonacci_in;
                    cnt_d   = '0;
                    acc_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (shift_q == '0) begin
                    bin_d   = acc_q[BIN_W-1:0];
                    ovf_d   = |acc_q[ACC_W-1:BIN_W];
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else if (shift_q[0]) begin
                    // cnt_b already points at this bit; ROM data arrives next cycle
                    state_d = StWait;
                end else begin
                    // A higher set bit exists, so cnt_b cannot pass the last address here
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            StWait: begin
                hold_d  = memb;
                state_d = StAcc;
            end
            StAcc: begin
                acc_d   = acc_q + ACC_W'(hold_q);
                shift_d = shift_q >> 1;
                // Keep the address inside the codeword after consuming the top bit
                if (cnt_q != LastAddr) begin
                    cnt_d = cnt_q + 1'b1;
                end
                state_d = StScan;
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any decode in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            hold_q  <= '0;
            bin_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            hold_q  <= hold_d;
            bin_q   <= bin_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign cnt_b       = cnt_q;
    assign binary_out  = bin_q;
    assign overflow    = ovf_q;
    assign decode_done = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_fib_random_decoder.sv
// Scoreboard bench for fib_random_decoder: directed words, hand-computed results and latencies.
module tb_fib_random_decoder;

    logic        clk;
    logic        rst;
    logic        en_decode;
    logic [63:0] fibonacci_in;
    logic [15:0] memb;
    logic [9:0]  cnt_b;
    logic [15:0] binary_out;
    logic        decode_done;
    logic        busy;
    logic        overflow;

    fib_random_decoder dut (
        .clk         (clk),
        .rst         (rst),
        .en_decode   (en_decode),
        .fibonacci_in(fibonacci_in),
        .memb        (memb),
        .cnt_b       (cnt_b),
        .binary_out  (binary_out),
        .decode_done (decode_done),
        .busy        (busy),
        .overflow    (overflow)
    );

    typedef struct {
        string       name;
        logic [15:0] val;
        logic        ovf;
        int          done_cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [15:0] rom [64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Saturating F(i+2) table, 1-cycle registered read
    initial begin
        int unsigned a, b, t;
        a = 1;
        b = 2;
        for (int i = 0; i < 64; i++) begin
            rom[i] = (a > 65535) ? 16'hFFFF : a[15:0];
            t = a + b;
            a = b;
            b = (t > 65536) ? 65536 : t;
        end
    end

    always @(posedge clk) memb <= rom[cnt_b[5:0]];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result
    always @(negedge clk) begin
        if (rst && cnt_b > 10'd63) begin
            errors++;
            $display("FAIL cnt_b_range: got %0d expected <= 63", cnt_b);
        end
        if (decode_done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (value %0d)", binary_out);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, "_value"}, binary_out, e.val);
                check({e.name, "_overflow"}, overflow, e.ovf);
                check({e.name, "_latency"}, cyc, e.done_cyc);
                check({e.name, "_busy_low"}, busy, 0);
            end
        end
    end

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    // Issue one request from negedge, push the expectation at the accepting edge
    task automatic decode(input string name, input logic [63:0] w, input logic [15:0] val,
                          input logic ovf, input int lat);
        exp_t e;
        @(negedge clk);
        fibonacci_in = w;
        en_decode    = 1'b1;
        @(posedge clk);
        #1;
        e.name = name; e.val = val; e.ovf = ovf; e.done_cyc = cyc + lat;
        sb_q.push_back(e);
        en_decode = 1'b0;
        wait_drain(name);
    endtask

    initial begin
        exp_t e;
        int   n;
        rst          = 1'b0;
        en_decode    = 1'b0;
        fibonacci_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cnt_b", cnt_b, 0);
        check("reset_binary_out", binary_out, 0);
        check("reset_done", decode_done, 0);
        check("reset_busy", busy, 0);
        check("reset_overflow", overflow, 0);
        rst = 1'b1;

        // All-zero word: one SCAN edge, busy for exactly one cycle
        @(negedge clk);
        fibonacci_in = 64'h0;
        en_decode    = 1'b1;
        @(posedge clk);
        #1;
        e.name = "zero"; e.val = 16'd0; e.ovf = 1'b0; e.done_cyc = cyc + 1;
        sb_q.push_back(e);
        en_decode = 1'b0;
        check("zero_busy_after_accept", busy, 1);
        wait_drain("zero");

        decode("w1",     64'h1,           16'd1,    1'b0, 4);
        decode("w15",    64'h15,          16'd12,   1'b0, 12);
        decode("w3",     64'h3,           16'd3,    1'b0, 7);
        decode("w4",     64'h4,           16'd3,    1'b0, 6);
        decode("ovf2122", 64'h0000_0000_0060_0000, 16'd9489, 1'b1, 1 + 23 + 4);
        decode("top63",  64'h8000_0000_0000_0000, 16'hFFFF, 1'b0, 1 + 64 + 2);

        // en_decode held: mid-run input change ignored, re-capture in the done cycle
        @(negedge clk);
        fibonacci_in = 64'h15;
        en_decode    = 1'b1;
        @(posedge clk);
        #1;
        e.name = "hold_first"; e.val = 16'd12; e.ovf = 1'b0; e.done_cyc = cyc + 12;
        sb_q.push_back(e);
        repeat (3) @(posedge clk);
        #1;
        fibonacci_in = 64'h4;
        check("hold_busy_mid", busy, 1);
        n = 0;
        while (!decode_done && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("hold_done_seen", decode_done, 1);
        @(posedge clk);
        #1;
        e.name = "hold_second"; e.val = 16'd3; e.ovf = 1'b0; e.done_cyc = cyc + 6;
        sb_q.push_back(e);
        en_decode = 1'b0;
        check("hold_recapture_busy", busy, 1);
        wait_drain("hold");

        // Reset mid-SCAN of 0xFF aborts without a done pulse
        @(negedge clk);
        fibonacci_in = 64'hFF;
        en_decode    = 1'b1;
        @(posedge clk);
        #1;
        en_decode = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        check("abort_busy", busy, 0);
        check("abort_cnt_b", cnt_b, 0);
        check("abort_binary_out", binary_out, 0);
        check("abort_overflow", overflow, 0);
        check("abort_done", decode_done, 0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("abort_stays_idle", busy, 0);
        decode("after_abort", 64'h1, 16'd1, 1'b0, 4);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
